// File: rtl/mips_debug_pkg.sv
// -----------------------------------------------------------------------------
// mips_debug_pkg
// Shared definitions for the MIPS debug read-out blocks (register dump and
// memory dump).
//   NB_BYTE         : width of one byte on the debug UART stream
//   dump_state_e    : dump FSM state encoding (CKSUM is only reached when the
//                     REGDUMP_CHECKSUM_EN build option is defined)
//   BYTES_PER_WORD  : number of bytes needed to stream one word of `width` bits
// No ports (package).
// -----------------------------------------------------------------------------
package mips_debug_pkg;

  localparam int NB_BYTE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_CKSUM = 3'd3,
    ST_DONE  = 3'd4
  } dump_state_e;

  function automatic int BYTES_PER_WORD(input int width);
    return width / NB_BYTE;
  endfunction

endpackage

// File: rtl/register_dump_if.sv
// -----------------------------------------------------------------------------
// register_dump_if
// Bundles the register-file read port and the byte stream towards the UART TX.
//   rd_addr  : register address (dump block -> register file)
//   rd_data  : combinational read data for rd_addr (register file -> dump block)
//   tx_data  : byte to the transmitter
//   tx_valid : tx_data holds a byte
//   tx_ready : transmitter accepts the byte this cycle
// Modports: master = dump block side, slave = register file / transmitter side.
// -----------------------------------------------------------------------------
interface register_dump_if #(
  parameter int width = 32,
  parameter int NB    = 5
);
  import mips_debug_pkg::*;

  logic [NB-1:0]      rd_addr;
  logic [width-1:0]   rd_data;
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output rd_addr,
    input  rd_data,
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  rd_addr,
    output rd_data,
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/word_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
// Captures one word and shifts it out least significant byte first over a
// valid/ready handshake.
//   clk, reset : clock, asynchronous active-low reset
//   i_load     : capture i_word and start presenting its first byte
//   i_word     : word to serialise
//   i_ready    : downstream accepts the presented byte
//   o_byte     : presented byte (low byte of the shift register)
//   o_valid    : o_byte holds a byte not yet accepted
//   o_last     : presented byte is the last byte of the word
//   o_xfer     : a byte is accepted on the coming clock edge
// -----------------------------------------------------------------------------
module word_serializer
  import mips_debug_pkg::*;
#(
  parameter int width = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [width-1:0]   i_word,
  input  logic               i_ready,
  output logic [NB_BYTE-1:0] o_byte,
  output logic               o_valid,
  output logic               o_last,
  output logic               o_xfer
);

  localparam int BPW    = BYTES_PER_WORD(width);
  localparam int NB_CNT = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [NB_CNT-1:0] LAST_CNT = NB_CNT'(BPW - 1);

  logic [width-1:0]  r_shift;
  logic [NB_CNT-1:0] r_cnt;
  logic              r_valid;
  logic              w_xfer;

  assign w_xfer = r_valid & i_ready;

  // Word capture, byte shifting and byte counting; valid drops with the last byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_xfer) begin
      r_shift <= r_shift >> NB_BYTE;
      r_cnt   <= r_cnt + NB_CNT'(1);
      r_valid <= (r_cnt != LAST_CNT);
    end
  end

  assign o_byte  = r_shift[NB_BYTE-1:0];
  assign o_valid = r_valid;
  assign o_last  = (r_cnt == LAST_CNT);
  assign o_xfer  = w_xfer;

endmodule

// File: rtl/register_dump.sv
// -----------------------------------------------------------------------------
// register_dump
// Debug reader for the MIPS register file: on start, reads every register
// through the combinational read port and streams each word as bytes (LSB
// first) to the debug UART transmitter.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   start : dump request, honoured only while idle
//   busy  : dump in progress
//   done  : one-cycle pulse when the dump completes
//   bus   : register_dump_if.master (rd_addr/rd_data, tx_data/tx_valid/tx_ready)
// Build option: REGDUMP_CHECKSUM_EN appends one byte holding the XOR of all
// data bytes sent in the dump.
// The pipeline must not write the register file while busy is high.
// -----------------------------------------------------------------------------
module register_dump
  import mips_debug_pkg::*;
#(
  parameter int width  = 32,
  parameter int length = 32,
  parameter int NB     = $clog2(length)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  register_dump_if.master bus
);

  localparam logic [NB-1:0] LAST_IDX = NB'(length - 1);

  dump_state_e        r_state;
  dump_state_e        w_state_next;
  logic [NB-1:0]      r_index;
  logic               r_busy;
  logic               r_done;
  logic               w_busy;
  logic               w_done;
  logic               w_load;
  logic               w_word_end;
  logic               w_start_ok;
  logic [NB_BYTE-1:0] w_ser_byte;
  logic               w_ser_valid;
  logic               w_ser_last;
  logic               w_ser_xfer;
`ifdef REGDUMP_CHECKSUM_EN
  logic [NB_BYTE-1:0] r_cksum;
`endif

  assign w_load     = (r_state == ST_FETCH);
  assign w_word_end = w_ser_xfer & w_ser_last;
  assign w_start_ok = (r_state == ST_IDLE) & start;

  word_serializer #(.width(width)) u_word_serializer (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_word  (bus.rd_data),
    .i_ready (bus.tx_ready),
    .o_byte  (w_ser_byte),
    .o_valid (w_ser_valid),
    .o_last  (w_ser_last),
    .o_xfer  (w_ser_xfer)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        w_state_next = ST_SEND;
      end
      ST_SEND: begin
        if (w_word_end) begin
          if (r_index == LAST_IDX) begin
`ifdef REGDUMP_CHECKSUM_EN
            w_state_next = ST_CKSUM;
`else
            w_state_next = ST_DONE;
`endif
          end else begin
            w_state_next = ST_FETCH;
          end
        end else begin
          w_state_next = ST_SEND;
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      ST_CKSUM: begin
        if (bus.tx_ready) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_CKSUM;
        end
      end
`endif
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the next state so the registered copies line up with the state
  always_comb begin
    w_busy = (w_state_next != ST_IDLE);
    w_done = (w_state_next == ST_DONE);
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy;
      r_done <= w_done;
    end
  end

  // Register index: restarts at 0 on each accepted start, saturates at the last register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index <= '0;
    end else if (w_start_ok) begin
      r_index <= '0;
    end else if (w_word_end && (r_index != LAST_IDX)) begin
      r_index <= r_index + NB'(1);
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  // XOR of every accepted data byte; the checksum byte itself never passes the serializer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cksum <= '0;
    end else if (w_start_ok) begin
      r_cksum <= '0;
    end else if (w_ser_xfer) begin
      r_cksum <= r_cksum ^ w_ser_byte;
    end
  end

  assign bus.tx_data  = (r_state == ST_CKSUM) ? r_cksum : w_ser_byte;
  assign bus.tx_valid = w_ser_valid | (r_state == ST_CKSUM);
`else
  assign bus.tx_data  = w_ser_byte;
  assign bus.tx_valid = w_ser_valid;
`endif

  assign bus.rd_addr = r_index;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_register_dump.sv
// -----------------------------------------------------------------------------
// tb_register_dump
// Scoreboard bench for register_dump: each dump pushes the byte stream the
// register contents imply into a queue; a monitor pops and compares on every
// accepted byte, checks stall stability and the done pulse.
// Honours REGDUMP_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_register_dump;
  import mips_debug_pkg::*;

  localparam int WIDTH  = 32;
  localparam int LENGTH = 32;
  localparam int NBA    = 5;
  localparam int BPW    = WIDTH / 8;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int DONE_OFF = LENGTH * (BPW + 1) + 1;
`else
  localparam int DONE_OFF = LENGTH * (BPW + 1);
`endif

  logic        clk;
  logic        reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        tb_ready;
  logic [31:0] regs [LENGTH];

  register_dump_if #(.width(WIDTH), .NB(NBA)) bus ();

  assign bus.rd_data  = regs[bus.rd_addr];
  assign bus.tx_ready = tb_ready;

  register_dump #(.width(WIDTH), .length(LENGTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.master)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_done = 0;
  int          n_xfer = 0;
  int          last_xfer_cyc = -1;
  int          done_cyc = -1;
  int          ready_mode = 0;
  int          ph = 0;
  bit          stall_pending = 1'b0;
  logic [7:0]  stall_data;
  logic [7:0]  exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transmitter ready pattern: 0 = always ready, 1 = one cycle in three, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: tb_ready = 1'b1;
      1: begin
        ph = (ph + 1) % 3;
        tb_ready = (ph == 0);
      end
      default: tb_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (stall_pending) begin
        check("stall_valid_held", {31'd0, bus.tx_valid}, 32'd1);
        check("stall_data_held", {24'd0, bus.tx_data}, {24'd0, stall_data});
      end
      stall_pending = 1'b0;
      if (bus.tx_valid && tb_ready) begin
        n_xfer++;
        last_xfer_cyc = cyc + 1;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_byte: got 0x%0h, expected no byte", bus.tx_data);
        end else begin
          check("tx_byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        end
      end else if (bus.tx_valid) begin
        stall_pending = 1'b1;
        stall_data    = bus.tx_data;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        check("done_all_bytes_sent", exp_q.size(), 32'd0);
        check("done_after_last_xfer", cyc, last_xfer_cyc);
      end
    end
  end

  // Expected stream: every register LSB byte first, then optionally the XOR of them all
  task automatic push_expected();
    logic [7:0] x;
    logic [7:0] b;
    x = 8'h00;
    for (int i = 0; i < LENGTH; i++) begin
      for (int j = 0; j < BPW; j++) begin
        b = regs[i][8*j +: 8];
        exp_q.push_back(b);
        x = x ^ b;
      end
    end
`ifdef REGDUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic do_start(output int e0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  // Cycle-exact checks for a dump with tx_ready held high
  task automatic run_timeline(input int e0, input int d0, input bit inject);
    bit ok_busy;
    bit ok_addr;
    ok_busy = 1'b1;
    ok_addr = 1'b1;
    for (int k = 0; k <= DONE_OFF + 1; k++) begin
      @(negedge clk);
      if (k <= DONE_OFF) ok_busy = ok_busy & (busy === 1'b1);
      else               ok_busy = ok_busy & (busy === 1'b0);
      if ((k % (BPW + 1) == 0) && (k / (BPW + 1) < LENGTH))
        ok_addr = ok_addr & (bus.rd_addr === NBA'(k / (BPW + 1)));
      if (inject) start = (k == 9) || (k == 49);
    end
    start = 1'b0;
    check("busy_window", {31'd0, ok_busy}, 32'd1);
    check("rd_addr_steps", {31'd0, ok_addr}, 32'd1);
    check("done_count", n_done, d0 + 1);
    check("done_cycle", done_cyc - e0, DONE_OFF);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k;
    k = 0;
    while (n_done == d0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("done_within_budget", {31'd0, (n_done != d0)}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int d0;
    int x0;
    int k;
    reset    = 1'b0;
    start    = 1'b0;
    tb_ready = 1'b1;
    for (int i = 0; i < LENGTH; i++) regs[i] = 32'd0;

    #12;
    check("reset_rd_addr", {27'd0, bus.rd_addr}, 32'd0);
    check("reset_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("reset_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    #20 reset = 1'b1;

    // reg[1] = DEADBEEF, ready always high
    regs[1] = 32'hDEADBEEF;
    push_expected();
    d0 = n_done;
    do_start(e0);
    run_timeline(e0, d0, 1'b0);

    // Same contents, ready one cycle in three
    ready_mode = 1;
    push_expected();
    d0 = n_done;
    do_start(e0);
    wait_done(d0, 2000);
    ready_mode = 0;

    // Starts at e10 and e50 are ignored; a start after done restarts from reg 0
    push_expected();
    d0 = n_done;
    do_start(e0);
    run_timeline(e0, d0, 1'b1);
    push_expected();
    d0 = n_done;
    do_start(e0);
    run_timeline(e0, d0, 1'b0);

    // Reset in the middle of byte 50, then a full dump
    for (int i = 0; i < LENGTH; i++) regs[i] = $urandom();
    ready_mode = 2;
    push_expected();
    d0 = n_done;
    x0 = n_xfer;
    do_start(e0);
    k = 0;
    while ((n_xfer - x0) < 50 && k < 2000) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("reached_byte_50", n_xfer - x0, 32'd50);
    @(posedge clk);
    #3 reset = 1'b0;
    exp_q.delete();
    stall_pending = 1'b0;
    #1;
    check("midreset_rd_addr", {27'd0, bus.rd_addr}, 32'd0);
    check("midreset_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("midreset_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_no_done", n_done, d0);
    #20 reset = 1'b1;
    push_expected();
    d0 = n_done;
    do_start(e0);
    wait_done(d0, 3000);

    // reg[i] = i, ready always high
    ready_mode = 0;
    tb_ready   = 1'b1;
    for (int i = 0; i < LENGTH; i++) regs[i] = i;
    push_expected();
    d0 = n_done;
    do_start(e0);
    run_timeline(e0, d0, 1'b0);

    // Random contents with random back-pressure
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < LENGTH; i++) regs[i] = $urandom();
      push_expected();
      d0 = n_done;
      do_start(e0);
      wait_done(d0, 3000);
    end

    @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_dump.md
# register_dump

Debug-side reader for the MIPS register file: on a `start` pulse it walks every register through the register file's combinational read port and streams each word out as bytes on a valid/ready byte interface feeding the UART transmitter. It sits between the register file and the debug UART TX, and is the read-out counterpart of the pipeline's write port. The pipeline must not write the register file while `busy` is high; the block does not guard against this.

## Interface
- `width`, 32: register word width in bits; multiple of 8.
- `length`, 32: number of registers dumped.
- `NB`, `$clog2(length)`: register address width.
- `NB_BYTE`, 8: output byte width.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle dump request; sampled only in IDLE.
- `rd_addr`  out  NB  register address driven to the register file read port.
- `rd_data`  in  width  combinational read data for `rd_addr`, valid in the same cycle.
- `tx_data`  out  NB_BYTE  byte to the UART transmitter.
- `tx_valid`  out  1  `tx_data` holds a byte.
- `tx_ready`  in  1  transmitter accepts the byte.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, FETCH, SEND, CKSUM (only when the macro is defined), DONE.
- IDLE: when `start`=1, clear the index and go to FETCH. `start` is ignored in every other state.
- FETCH: drive `rd_addr`=index. At the clock edge, load `rd_data` into the word shift register, clear the byte counter, and go to SEND.
- SEND: `tx_data` is the low byte of the shift register, so bytes go out least significant first, and `tx_valid`=1.
  - A transfer occurs on a clock edge when `tx_valid` and `tx_ready` are both 1. On a transfer, shift right by `NB_BYTE` and increment the byte counter.
  - After byte `width/8-1`: if index < `length`-1, increment the index and go to FETCH; otherwise go to CKSUM (macro defined) or DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `busy`=1 in every state except IDLE.
- `tx_valid`=0 outside SEND and CKSUM.
- While stalled (`tx_ready`=0), `tx_data` and `tx_valid` hold unchanged. `tx_valid` never drops before its transfer.
- Index wrap-around is impossible: the index stops at `length`-1.

## Timing
- Reset (`reset`=0) takes effect immediately, with no clock edge:
  - state goes to IDLE;
  - `rd_addr`=0, `tx_data`=0, `tx_valid`=0, `busy`=0, `done`=0;
  - index, byte counter and checksum are cleared.
- Reset mid-dump abandons the remaining bytes. The next `start` restarts from register 0.
- With `start` sampled at edge e0 and `tx_ready` held at 1:
  - each register takes 5 cycles (1 FETCH + 4 SEND for width 32);
  - the last data transfer is at e160;
  - `done` is high in the cycle between e160 and e161.
- With the macro defined, the checksum transfers at e161 and `done` is high between e161 and e162.
- Each cycle of `tx_ready`=0 during SEND or CKSUM delays every later event by one cycle.
- `start` and `done` can coincide only if `start` arrives in DONE; that `start` is ignored.

## Configuration
- `REGDUMP_CHECKSUM_EN` defined:
  - the block accumulates the XOR of every transmitted data byte;
  - after the last data byte it enters CKSUM and sends that XOR as one extra byte with the same handshake;
  - the accumulator clears on each accepted `start`.
- Not defined: the CKSUM state and the accumulator are absent, and exactly `length`*`width`/8 bytes are sent.

## Structure
- Shared package `mips_debug_pkg` holds:
  - the state encoding (IDLE, FETCH, SEND, CKSUM, DONE);
  - `NB_BYTE`;
  - a `BYTES_PER_WORD` function (`width`/8), reused by the memory-dump block.
- One sub-module, `word_serializer`: load the word, then shift it out byte by byte with the valid/ready handshake and a last-byte flag. The top level keeps the FSM, index and checksum.

## Test plan
- reg[1]=0xDEADBEEF, all others 0, `tx_ready`=1, `start` at e0 -> 128 bytes; bytes 4..7 = EF, BE, AD, DE; all other bytes 00; `done` between e160 and e161; `busy` high from e0 to e161.
- Same contents, `tx_ready` high one cycle in three -> identical byte sequence; `tx_data` stable and `tx_valid`=1 through every stall; `done` after the 128th transfer.
- `start` pulsed at e10 and e50 during a dump -> ignored; a `start` after `done` restarts from reg[0] with the same 128 bytes.
- `reset`=0 asserted mid-cycle during byte 50 -> all outputs 0 immediately, with no clock edge; after release, `start` gives a full 128-byte dump from reg[0].
- With `REGDUMP_CHECKSUM_EN` defined and the same contents -> 129 bytes, last byte 0x22; `done` between e161 and e162.
- reg[i]=i for all i, `tx_ready`=1 -> byte 4i = i, the other three bytes of each word 00; `rd_addr` steps 0..31, one step per 5 cycles.
